// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_unit
//  Purpose  : Flag register plus a single-branch resolver that issues a PC
//             redirect and a multi-cycle flush on taken branches.
//             Optional feature macro: FLAG_BYPASS_EN (flag write forwarding
//             into the resolve cycle).
//  Revision : 1.0  initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int PC_WIDTH     = 16,
    parameter int COND_BITS    = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flag_we,
    input  logic                 flag_zero,
    input  logic                 flag_less,
    input  logic                 flag_greater,
    input  logic                 br_valid,
    output logic                 br_ready,
    input  logic [COND_BITS-1:0] br_cond,
    input  logic [PC_WIDTH-1:0]  br_target,
    input  logic                 br_cmp_eq,
    output logic                 redirect_valid,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 resolved,
    output logic                 taken,
    output logic                 flush,
    output logic [2:0]           flags_q
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESOLVE = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    // Remaining FLUSH-state cycles after the redirect cycle (which always flushes).
    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES <= 1) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

    state_t                state_q, state_d;
    logic [COND_BITS-1:0]  cond_q, cond_d;
    logic [PC_WIDTH-1:0]   target_q, target_d;
    logic                  cmp_eq_q, cmp_eq_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]   last_pc_q, last_pc_d;
    logic [2:0]            flags_d;
    logic [2:0]            eval_flags;
    logic                  cond_true;

    always_comb begin
        eval_flags = flags_q;
`ifdef FLAG_BYPASS_EN
        if (flag_we) begin
            eval_flags = {flag_zero, flag_less, flag_greater};
        end
`endif
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond_q)
            COND_BITS'(0): cond_true = 1'b1;
            COND_BITS'(1): cond_true = eval_flags[2];
            COND_BITS'(2): cond_true = ~eval_flags[2];
            COND_BITS'(3): cond_true = eval_flags[1];
            COND_BITS'(4): cond_true = eval_flags[0];
            COND_BITS'(5): cond_true = eval_flags[2] | eval_flags[1];
            COND_BITS'(6): cond_true = eval_flags[2] | eval_flags[0];
            COND_BITS'(7): cond_true = cmp_eq_q;
            default:       cond_true = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cond_d         = cond_q;
        target_d       = target_q;
        cmp_eq_d       = cmp_eq_q;
        cnt_d          = cnt_q;
        last_pc_d      = last_pc_q;
        flags_d        = flag_we ? {flag_zero, flag_less, flag_greater} : flags_q;
        br_ready       = 1'b0;
        resolved       = 1'b0;
        taken          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = last_pc_q;
        flush          = 1'b0;

        case (state_q)
            S_IDLE: begin
                br_ready = 1'b1;
                if (br_valid) begin
                    cond_d   = br_cond;
                    target_d = br_target;
                    cmp_eq_d = br_cmp_eq;
                    state_d  = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                resolved = 1'b1;
                taken    = cond_true;
                state_d  = S_IDLE;
                if (cond_true) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = target_q;
                    last_pc_d      = target_q;
                    flush          = 1'b1;
                    if (FLUSH_LOAD != 4'd0) begin
                        cnt_d   = FLUSH_LOAD;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                flush = 1'b1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cond_q    <= '0;
            target_q  <= '0;
            cmp_eq_q  <= 1'b0;
            cnt_q     <= 4'd0;
            last_pc_q <= '0;
            flags_q   <= 3'b000;
        end else begin
            state_q   <= state_d;
            cond_q    <= cond_d;
            target_q  <= target_d;
            cmp_eq_q  <= cmp_eq_d;
            cnt_q     <= cnt_d;
            last_pc_q <= last_pc_d;
            flags_q   <= flags_d;
        end
    end

endmodule
`default_nettype wire
